// File: rtl/mem_ctrl_pkg.sv
// Shared types and default sizing for the burst memory controller.
package mem_ctrl_pkg;
    localparam int DEF_ADDR_WIDTH = 3;
    localparam int DEF_DATA_WIDTH = 4;
    localparam int DEF_DEPTH      = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2
    } state_e;
endpackage

// File: rtl/mem_addr_wrap.sv
// Loadable address pointer that wraps from DEPTH-1 back to 0.
module mem_addr_wrap #(
    parameter int ADDR_WIDTH = 3,
    parameter int DEPTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_i,
    input  logic [ADDR_WIDTH-1:0] load_val_i,
    input  logic                  inc_i,
    output logic [ADDR_WIDTH-1:0] ptr_o,
    output logic [ADDR_WIDTH-1:0] ptr_succ_o
);
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;

    // Successor is independent of inc_i so callers can use it without a comb loop.
    assign ptr_succ_o = (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
    assign ptr_o      = ptr_q;

    always_comb begin
        ptr_d = ptr_q;
        if (load_i)     ptr_d = load_val_i;
        else if (inc_i) ptr_d = ptr_succ_o;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end
endmodule

// File: rtl/mem_burst_ctrl.sv
// Burst read/write controller for a single-port memory with 1-cycle latency.
// Optional start-address range check: MEM_BURST_CTRL_RANGE_CHECK_EN.
module mem_burst_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_wr,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [ADDR_WIDTH-1:0] cmd_len,
    input  logic                  wdata_valid,
    output logic                  wdata_ready,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  rdata_valid,
    input  logic                  rdata_ready,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    output logic                  mem_wr,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    output logic                  done,
    output logic                  err
);
    localparam logic [ADDR_WIDTH:0] DEPTH_X = DEPTH[ADDR_WIDTH:0];

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_din_q, mem_din_d;
    logic                  mem_wr_q, mem_wr_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rvalid_q, rvalid_d;
    logic                  last_iss_q, last_iss_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic                  ptr_load, ptr_inc, issue;
    logic [ADDR_WIDTH-1:0] ptr, ptr_succ, start_addr;
    logic                  addr_oor;

`ifdef MEM_BURST_CTRL_RANGE_CHECK_EN
    assign addr_oor   = ({1'b0, cmd_addr} >= DEPTH_X);
    assign start_addr = cmd_addr;
`else
    assign addr_oor   = 1'b0;
    assign start_addr = ADDR_WIDTH'({1'b0, cmd_addr} % DEPTH_X);
`endif

    mem_addr_wrap #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ptr (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (ptr_load),
        .load_val_i (start_addr),
        .inc_i      (ptr_inc),
        .ptr_o      (ptr),
        .ptr_succ_o (ptr_succ)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_addr_d  = mem_addr_q;
        mem_din_d   = mem_din_q;
        mem_wr_d    = 1'b0;
        rdata_d     = rdata_q;
        rvalid_d    = rvalid_q;
        last_iss_d  = last_iss_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        ptr_load    = 1'b0;
        ptr_inc     = 1'b0;
        issue       = 1'b0;
        cmd_ready   = 1'b0;
        wdata_ready = 1'b0;

        case (state_q)
            IDLE: begin
                cmd_ready  = 1'b1;
                last_iss_d = 1'b0;
                if (cmd_valid) begin
                    if (addr_oor) begin
                        err_d = 1'b1;
                    end else begin
                        ptr_load = 1'b1;
                        cnt_d    = cmd_len;
                        if (cmd_wr) begin
                            state_d = WR;
                        end else begin
                            state_d    = RD;
                            mem_addr_d = start_addr;
                        end
                    end
                end
            end
            WR: begin
                wdata_ready = 1'b1;
                if (wdata_valid) begin
                    mem_wr_d   = 1'b1;
                    mem_addr_d = ptr;
                    mem_din_d  = wdata;
                    ptr_inc    = 1'b1;
                    if (cnt_q == '0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            RD: begin
                // mem_addr already holds the pending beat; capture it when the output slot frees up.
                issue = !last_iss_q && (!rvalid_q || rdata_ready);
                if (rvalid_q && rdata_ready) rvalid_d = 1'b0;
                if (issue) begin
                    rdata_d    = mem_dout;
                    rvalid_d   = 1'b1;
                    ptr_inc    = 1'b1;
                    mem_addr_d = ptr_succ;
                    if (cnt_q == '0) last_iss_d = 1'b1;
                    else             cnt_d      = cnt_q - 1'b1;
                end
                if (last_iss_q && rvalid_q && rdata_ready) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            mem_wr_q   <= 1'b0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
            last_iss_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            mem_wr_q   <= mem_wr_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
            last_iss_q <= last_iss_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign mem_addr    = mem_addr_q;
    assign mem_din     = mem_din_q;
    assign mem_wr      = mem_wr_q;
    assign rdata       = rdata_q;
    assign rdata_valid = rvalid_q;
    assign done        = done_q;
    assign err         = err_q;
endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Scoreboard bench for mem_burst_ctrl with a behavioural memory reference.
module tb_mem_burst_ctrl;
    localparam int AW = 3, DW = 4, DEPTH = 6;

    logic clk = 1'b0, rst_n = 1'b0;
    logic cmd_valid = 1'b0, cmd_ready, cmd_wr = 1'b0;
    logic [AW-1:0] cmd_addr = '0, cmd_len = '0;
    logic wdata_valid = 1'b0, wdata_ready;
    logic [DW-1:0] wdata = '0;
    logic rdata_valid, rdata_ready = 1'b0;
    logic [DW-1:0] rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din, mem_dout;
    logic mem_wr, done, err;

    always #5 clk = ~clk;

    mem_burst_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
        .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_wr(mem_wr), .mem_dout(mem_dout),
        .done(done), .err(err)
    );

    // Memory attached to the controller.
    logic [DW-1:0] mem [DEPTH];
    initial for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    always @(posedge clk) if (mem_wr && int'(mem_addr) < DEPTH) mem[int'(mem_addr)] <= mem_din;
    assign mem_dout = (int'(mem_addr) < DEPTH) ? mem[int'(mem_addr)] : '0;

    // Reference contents and expectation queues.
    typedef struct { int a; int d; } wr_t;
    int  ref_mem [DEPTH];
    wr_t wq[$];
    int  rq[$];
    int  total = 0, bad = 0;
    int  done_seen = 0, done_exp = 0, err_seen = 0, err_exp = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    // Monitor
    logic [DW-1:0] prev_rdata = '0;
    logic          prev_stall = 1'b0;
    always @(negedge clk) begin
        wr_t w;
        int  e;
        if (mem_wr) begin
            if (wq.size() == 0) chk("spurious_wr", int'(mem_wr), 0);
            else begin
                w = wq.pop_front();
                chk("wr_addr", int'(mem_addr), w.a);
                chk("wr_data", int'(mem_din), w.d);
            end
        end
        if (prev_stall) begin
            chk("rd_hold_valid", int'(rdata_valid), 1);
            chk("rd_hold_data", int'(rdata), int'(prev_rdata));
        end
        if (rdata_valid && rdata_ready) begin
            if (rq.size() == 0) chk("spurious_rd", int'(rdata_valid), 0);
            else begin
                e = rq.pop_front();
                chk("rd_data", int'(rdata), e);
            end
        end
        if (cmd_ready) chk("idle_excl", int'(wdata_ready | rdata_valid), 0);
        prev_stall = rdata_valid && !rdata_ready;
        prev_rdata = rdata;
        if (done) done_seen++;
        if (err)  err_seen++;
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic end_checks();
        repeat (2) tick();
        chk("done_cnt", done_seen, done_exp);
        chk("err_cnt", err_seen, err_exp);
        chk("wq_empty", wq.size(), 0);
        chk("rq_empty", rq.size(), 0);
        chk("back_idle", int'(cmd_ready), 1);
    endtask

    task automatic send_cmd(input bit wr, input int a, input int l, output bit oor);
        int t = 0;
        while (!cmd_ready && t < 100) begin tick(); t++; end
        chk("cmd_ready_wait", int'(cmd_ready), 1);
        cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = AW'(a); cmd_len = AW'(l);
        tick();
        cmd_valid = 1'b0;
`ifdef MEM_BURST_CTRL_RANGE_CHECK_EN
        oor = (a >= DEPTH);
`else
        oor = 1'b0;
`endif
        if (oor) begin
            err_exp++;
            end_checks();
        end
    endtask

    task automatic do_write(input int a, input int l, input int dbase,
                            input int gap_beat, input int gap_len, input bit rnd);
        bit oor;
        int d, g, t, ad;
        send_cmd(1'b1, a, l, oor);
        if (oor) return;
        for (int i = 0; i <= l; i++) begin
            g = (i == gap_beat) ? gap_len : (rnd ? int'($urandom_range(0, 2)) - 1 : 0);
            if (g > 0) begin wdata_valid = 1'b0; repeat (g) tick(); end
            d  = (dbase >= 0) ? dbase + i : int'($urandom_range(0, 15));
            ad = (a + i) % DEPTH;
            wdata_valid = 1'b1; wdata = DW'(d);
            t = 0;
            while (!wdata_ready && t < 100) begin tick(); t++; end
            chk("wready_wait", int'(wdata_ready), 1);
            wq.push_back('{a: ad, d: d});
            ref_mem[ad] = d;
            tick();
        end
        wdata_valid = 1'b0;
        done_exp++;
        end_checks();
    endtask

    task automatic do_read(input int a, input int l, input int stall_beat, input bit rnd);
        bit oor, stalled;
        int got, t, held;
        send_cmd(1'b0, a, l, oor);
        if (oor) return;
        for (int i = 0; i <= l; i++) rq.push_back(ref_mem[(a + i) % DEPTH]);
        got = 0; t = 0; stalled = 1'b0;
        while (got <= l && t < 500) begin
            if (got == stall_beat && rdata_valid && !stalled) begin
                stalled = 1'b1;
                rdata_ready = 1'b0;
                held = int'(mem_addr);
                repeat (3) begin tick(); chk("stall_addr", int'(mem_addr), held); end
            end
            rdata_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (rdata_valid && rdata_ready) got++;
            tick();
            t++;
        end
        rdata_ready = 1'b0;
        chk("rd_beats", got, l + 1);
        done_exp++;
        end_checks();
    endtask

    task automatic reset_mid_write();
        bit oor;
        int t = 0;
        send_cmd(1'b1, 1, 3, oor);
        wdata_valid = 1'b1; wdata = 4'h5;
        while (!wdata_ready && t < 100) begin tick(); t++; end
        tick();
        // Beat 1's write would appear now; reset before the monitor sees it.
        wdata = 4'h6;
        rst_n = 1'b0;
        #1;
        chk("rst_mem_wr", int'(mem_wr), 0);
        chk("rst_cmd_ready", int'(cmd_ready), 1);
        chk("rst_wready", int'(wdata_ready), 0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        wdata_valid = 1'b0;
        chk("post_rst_ready", int'(cmd_ready), 1);
        end_checks();
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 0;
        #2;
        chk("rst_mem_wr0", int'(mem_wr), 0);
        chk("rst_mem_addr0", int'(mem_addr), 0);
        chk("rst_mem_din0", int'(mem_din), 0);
        chk("rst_rdata0", int'(rdata), 0);
        chk("rst_rvalid0", int'(rdata_valid), 0);
        chk("rst_done0", int'(done), 0);
        chk("rst_err0", int'(err), 0);
        chk("rst_cmd_ready0", int'(cmd_ready), 1);
        chk("rst_wready0", int'(wdata_ready), 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        do_write(0, DEPTH - 1, -1, -1, 0, 1'b0);   // prefill
        do_write(2, 3, 10, -1, 0, 1'b0);           // A,B,C,D at 2..5
        do_read(4, 3, -1, 1'b0);                   // 4,5,0,1 wrap
        do_read(0, 7, -1, 1'b0);                   // 8 beats across the wrap
        do_read(1, 3, 1, 1'b0);                    // stall on beat 2
        do_write(3, 3, -1, 2, 2, 1'b0);            // 2-cycle wdata gap
        do_read(3, 3, -1, 1'b0);
        reset_mid_write();
        do_read(1, 3, -1, 1'b0);                   // memory untouched by aborted burst
        do_write(7, 2, -1, -1, 0, 1'b0);           // out of range start
        do_read(0, 5, -1, 1'b0);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 1) == 1)
                do_write(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), -1,
                         int'($urandom_range(0, 8)), int'($urandom_range(1, 3)), 1'b1);
            else
                do_read(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                        int'($urandom_range(0, 8)), 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
